// File: rtl/ara_inval_broadcaster_if.sv
// AW valid/ready handshake plus per-hart invalidation bus between Ara, the
// system mux and the CVA6 cores.
interface ara_inval_broadcaster_if #(
  parameter int unsigned NrHarts   = 4,
  parameter int unsigned AddrWidth = 64
);
  logic                 slv_aw_valid_i;
  logic                 slv_aw_ready_o;
  logic [AddrWidth-1:0] slv_aw_addr_i;
  logic [7:0]           slv_aw_len_i;
  logic [2:0]           slv_aw_size_i;
  logic                 mst_aw_valid_o;
  logic                 mst_aw_ready_i;
  logic [AddrWidth-1:0] inval_addr_o;
  logic [NrHarts-1:0]   inval_valid_o;
  logic [NrHarts-1:0]   inval_ready_i;

  // Broadcaster side.
  modport master (
    input  slv_aw_valid_i, slv_aw_addr_i, slv_aw_len_i, slv_aw_size_i,
    input  mst_aw_ready_i, inval_ready_i,
    output slv_aw_ready_o, mst_aw_valid_o, inval_addr_o, inval_valid_o
  );

  // Environment side: Ara, mux and cores.
  modport slave (
    output slv_aw_valid_i, slv_aw_addr_i, slv_aw_len_i, slv_aw_size_i,
    output mst_aw_ready_i, inval_ready_i,
    input  slv_aw_ready_o, mst_aw_valid_o, inval_addr_o, inval_valid_o
  );
endinterface

// File: rtl/ara_inval_broadcaster.sv
// Snoops Ara's AW channel, splits each write burst into L1-line invalidations
// and broadcasts every line to all enabled CVA6 harts.
module ara_inval_broadcaster #(
  parameter int unsigned NrHarts      = 4,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned L1LineWidth  = 16,
  parameter int unsigned MaxTxns      = 4,
  parameter int unsigned LineCntWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [NrHarts-1:0]    hart_en_i,
  ara_inval_broadcaster_if.master bus,
  output logic                  busy_o
);

  localparam int unsigned LineBits = $clog2(L1LineWidth);
  localparam int unsigned CntW     = LineCntWidth + 1;
  localparam int unsigned PtrW     = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned OccW     = $clog2(MaxTxns + 1);

  typedef struct packed {
    logic [AddrWidth-1:0] base;
    logic [CntW-1:0]      nlines;
  } txn_t;

  typedef enum logic {IDLE, BCAST} state_e;

  txn_t                 fifo_q [MaxTxns];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]      cnt_q, cnt_next;
  logic                 full, empty, push, pop;
  txn_t                 new_txn, head;
  logic [CntW-1:0]      offset, bytes;

  state_e               state_q;
  logic [AddrWidth-1:0] cur_addr_q;
  logic [CntW-1:0]      remaining_q;
  logic [NrHarts-1:0]   mask_q, valid_q;
  logic                 busy_q;
  logic                 covered, last_line, bcast_next;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTxns - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Occupancy flags come from the registered count only, so a pop never
  // reaches AW ready combinationally.
  assign full  = (cnt_q == OccW'(MaxTxns));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // Valid/ready gating towards the mux; the AW payload bypasses this block.
  always_comb begin
    bus.mst_aw_valid_o = bus.slv_aw_valid_i;
    bus.slv_aw_ready_o = bus.mst_aw_ready_i;
    if (en_i) begin
      bus.mst_aw_valid_o = bus.slv_aw_valid_i & ~full;
      bus.slv_aw_ready_o = bus.mst_aw_ready_i & ~full;
    end
  end

  assign push = en_i & bus.slv_aw_valid_i & bus.slv_aw_ready_o;

  // Line-aligned base and number of lines touched by the burst.
  always_comb begin
    offset         = CntW'(bus.slv_aw_addr_i & AddrWidth'(L1LineWidth - 1));
    bytes          = (CntW'(bus.slv_aw_len_i) + CntW'(1)) << bus.slv_aw_size_i;
    new_txn.base   = bus.slv_aw_addr_i & ~AddrWidth'(L1LineWidth - 1);
    new_txn.nlines = ((offset + bytes - CntW'(1)) >> LineBits) + CntW'(1);
  end

  // A line is done once every masked hart has handshaked, now or earlier.
  assign covered   = ((valid_q & ~bus.inval_ready_i) == '0);
  assign last_line = (remaining_q == CntW'(1));

  always_comb begin
    pop        = 1'b0;
    bcast_next = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (hart_en_i == '0) pop = 1'b1;
          else                 bcast_next = 1'b1;
        end
      end
      BCAST: begin
        if (covered && last_line) pop = 1'b1;
        else                      bcast_next = 1'b1;
      end
    endcase
  end

  assign cnt_next = cnt_q + OccW'(push) - OccW'(pop);

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= new_txn;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mask_q      <= '0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q  <= cnt_next;
      busy_q <= (cnt_next != '0) | bcast_next;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case (state_q)
        IDLE: begin
          if (!empty && (hart_en_i != '0)) begin
            state_q     <= BCAST;
            cur_addr_q  <= head.base;
            remaining_q <= head.nlines;
            mask_q      <= hart_en_i;
            valid_q     <= hart_en_i;
          end
        end
        BCAST: begin
          if (covered) begin
            if (last_line) begin
              state_q <= IDLE;
              valid_q <= '0;
            end else begin
              // Address space wraps naturally at AddrWidth bits.
              cur_addr_q  <= cur_addr_q + AddrWidth'(L1LineWidth);
              remaining_q <= remaining_q - CntW'(1);
              valid_q     <= mask_q;
            end
          end else begin
            valid_q <= valid_q & ~bus.inval_ready_i;
          end
        end
      endcase
    end
  end

  assign bus.inval_addr_o  = cur_addr_q;
  assign bus.inval_valid_o = valid_q;
  assign busy_o            = busy_q;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
  a_valid_in_mask:     assert property (@(posedge clk_i) disable iff (rst_i) (valid_q & ~mask_q) == '0);

endmodule

// File: doc/ara_inval_broadcaster.md
Name: ara_inval_broadcaster

Overview:
Multi-hart successor of the single-core AXI invalidation filter in the Ara system. It snoops the AW channel of Ara's wide AXI master and splits every write burst into L1 cache-line-aligned invalidation requests. Each request is broadcast to up to NrHarts CVA6 cores, and each core acknowledges with its own ready. Placed between Ara's AXI master port and the system mux. Gives coherence across several scalar cores sharing one vector unit.

Parameters:
NrHarts, 4, number of CVA6 cores receiving invalidations (1..8)
AddrWidth, 64, AXI address width
L1LineWidth, 16, L1 D-cache line size in bytes (power of 2)
MaxTxns, 4, depth of pending-write FIFO (power of 2, >=1)
LineCntWidth, 16, width of per-burst line counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
en_i  in  1  coherence enable (acc_cons_en)
hart_en_i  in  NrHarts  per-hart invalidation enable mask
slv_aw_valid_i  in  1  AW valid from Ara
slv_aw_ready_o  out  1  AW ready to Ara
slv_aw_addr_i  in  AddrWidth  AW address
slv_aw_len_i  in  8  AW burst length (beats-1)
slv_aw_size_i  in  3  AW beat size (log2 bytes)
mst_aw_valid_o  out  1  AW valid to mux
mst_aw_ready_i  in  1  AW ready from mux
inval_addr_o  out  AddrWidth  line-aligned invalidation address (shared by all harts)
inval_valid_o  out  NrHarts  per-hart invalidation valid
inval_ready_i  in  NrHarts  per-hart invalidation ready
busy_o  out  1  FIFO non-empty or broadcast in progress

Behaviour:
- AW payload is forwarded externally. This block gates only the valid/ready pair.
- en_i=0: mst_aw_valid_o=slv_aw_valid_i and slv_aw_ready_o=mst_aw_ready_i (combinational). Nothing is pushed.
- en_i=1: mst_aw_valid_o=slv_aw_valid_i & !full and slv_aw_ready_o=mst_aw_ready_i & !full.
  - On fire (slv_aw_valid_i & slv_aw_ready_o), push {base, nlines}.
  - base = addr with log2(L1LineWidth) LSBs cleared.
  - bytes = (len+1)<<size.
  - nlines = ((addr mod L1LineWidth) + bytes - 1) / L1LineWidth + 1, computed at LineCntWidth+1 bits, no overflow.
- The FIFO accepts a push and a pop in the same cycle. A push while full cannot happen, because ready is gated. full is derived from the registered count, so there is no combinational path from pop to ready.
- FSM, states IDLE and BCAST:
  - IDLE: if the FIFO is non-empty, load cur_addr=base and remaining=nlines, capture mask=hart_en_i, clear done[], and go to BCAST next cycle.
  - IDLE with a captured mask of all zeros: pop immediately with no broadcast and stay IDLE.
  - BCAST: inval_addr_o=cur_addr and inval_valid_o[h]=mask[h] & !done[h].
  - A handshake on hart h sets done[h]. Harts may accept in different cycles, and valid holds until that hart's ready.
  - When (done | handshakes this cycle) covers the mask:
    - remaining>1: cur_addr += L1LineWidth, remaining -= 1, done cleared, and the next line is presented the next cycle.
    - remaining==1: pop, go to IDLE.
- Latency: 2 cycles from AW fire to first inval_valid_o when the FIFO was empty. Throughput is 1 line per cycle when all harts are ready.
- Address wrap at the top of the address space wraps modulo 2^AddrWidth.
- hart_en_i changes take effect only at the next burst capture.
- en_i falling while busy: queued entries still drain fully, and new AWs pass ungated.
- busy_o = FIFO non-empty | state==BCAST.
- Reset values: inval_valid_o=0, inval_addr_o=0, busy_o=0, FIFO empty, state IDLE. slv_aw_ready_o and mst_aw_valid_o follow their combinational equations.
- Reset mid-burst drops all queued and in-flight invalidations. Outputs return to reset values the cycle after rst_i is sampled high.

Test Plan:
- en_i=0, 10 random AWs -> valid/ready pass through unchanged, inval_valid_o stays 0, busy_o stays 0.
- en_i=1, mask=4'b1111, all ready, AW addr=0x1008 len=0 size=3 -> exactly one broadcast, inval_addr_o=0x1000 on all 4 harts, 2 cycles after fire.
- AW addr=0x100C len=3 size=3 (32 B, crosses 3 lines) -> inval_addr_o 0x1000, 0x1010, 0x1020 in consecutive cycles, then IDLE.
- Hart 2 ready delayed 5 cycles -> harts 0, 1, 3 drop valid after the first cycle, hart 2 holds valid and the same address, and the next line starts only after hart 2 accepts.
- MaxTxns+1 back-to-back AWs with inval_ready_i=0 -> slv_aw_ready_o=0 once 4 entries are queued, rises the cycle after the first pop. Also: hart_en_i=0 -> entries pop without any inval_valid_o.
- rst_i asserted in the middle of a 3-line burst -> next cycle inval_valid_o=0 and busy_o=0, and the following AW is processed from a clean state.
